// File: rtl/rd_req_engine.sv
// Read-request generator for the AFU c0Tx path: polls the control cache line while the
// AFU is in CTRL, then streams sequential data-line reads while it is in RUN.
module rd_req_engine #(
  parameter logic [15:0] CTRL_MDATA   = 16'h0001,
  parameter logic [15:0] RUN_MDATA    = 16'h0002,
  parameter int unsigned POLL_GAP     = 64,
  parameter int unsigned CTRL_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic [2:0]  afu_state_in_i,
  input  logic [41:0] ctrl_addr_i,
  input  logic        ctrl_resp_valid_i,
  input  logic [41:0] run_rd_addr_i,
  input  logic [31:0] run_num_cls_i,
  output logic        rd_valid_o,
  output logic [15:0] rd_mdata_o,
  output logic [41:0] rd_addr_o,
  output logic [31:0] rd_issued_o,
  output logic        rd_run_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL_ISSUE,
    S_CTRL_WAIT,
    S_CTRL_GAP,
    S_RUN,
    S_RUN_DONE
  } state_e;

  localparam logic [2:0]  AFU_CTRL     = 3'd1;
  localparam logic [2:0]  AFU_RUN      = 3'd2;
  localparam logic [31:0] TIMEOUT_LAST = 32'(CTRL_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST     = 32'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [41:0] base_q, base_d;
  logic [31:0] count_q, count_d;
  logic [31:0] issued_q, issued_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [15:0] mdata_q, mdata_d;
  logic [41:0] addr_q, addr_d;

  logic ctrl_phase;
  logic run_phase;
  logic launch;
  logic run_last;

  assign ctrl_phase = (afu_state_in_i == AFU_CTRL);
  assign run_phase  = (afu_state_in_i == AFU_RUN);

  // A launch ignores the phase input so a request decided in an exit cycle still goes out.
  assign launch = !stall_i &&
                  ((state_q == S_CTRL_ISSUE) ||
                   ((state_q == S_RUN) && (issued_q != count_q)));

  assign run_last = (issued_q == count_q) ||
                    (launch && ((issued_q + 32'd1) == count_q));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_phase) begin
          state_d = S_CTRL_ISSUE;
        end else if (run_phase) begin
          state_d = S_RUN;
        end
      end
      S_CTRL_ISSUE: begin
        if (!ctrl_phase) begin
          state_d = S_IDLE;
        end else if (launch) begin
          state_d = S_CTRL_WAIT;
        end
      end
      S_CTRL_WAIT: begin
        if (!ctrl_phase) begin
          state_d = S_IDLE;
        end else if (ctrl_resp_valid_i) begin
          state_d = S_CTRL_GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = S_CTRL_ISSUE;
        end
      end
      S_CTRL_GAP: begin
        if (!ctrl_phase) begin
          state_d = S_IDLE;
        end else if (timer_q == GAP_LAST) begin
          state_d = S_CTRL_ISSUE;
        end
      end
      S_RUN: begin
        if (!run_phase) begin
          state_d = S_IDLE;
        end else if (run_last) begin
          state_d = S_RUN_DONE;
        end
      end
      S_RUN_DONE: begin
        if (!run_phase) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer restarts at zero on every entry into WAIT or GAP because the states feeding
  // them leave it cleared; issued/done survive leaving RUN until the next RUN entry.
  always_comb begin
    valid_d  = launch;
    mdata_d  = mdata_q;
    addr_d   = addr_q;
    issued_d = issued_q;
    done_d   = done_q;
    base_d   = base_q;
    count_d  = count_q;
    timer_d  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (!ctrl_phase && run_phase) begin
          base_d   = run_rd_addr_i;
          count_d  = run_num_cls_i;
          issued_d = 32'd0;
          done_d   = 1'b0;
        end
      end
      S_CTRL_ISSUE: begin
        if (launch) begin
          addr_d  = ctrl_addr_i;
          mdata_d = CTRL_MDATA;
        end
      end
      S_CTRL_WAIT: begin
        if (!ctrl_resp_valid_i) begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_CTRL_GAP: begin
        timer_d = timer_q + 32'd1;
      end
      S_RUN: begin
        if (launch) begin
          addr_d   = base_q + {10'd0, issued_q};
          mdata_d  = RUN_MDATA;
          issued_d = issued_q + 32'd1;
        end
        done_d = run_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q  <= 32'd0;
      base_q   <= 42'd0;
      count_q  <= 32'd0;
      issued_q <= 32'd0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      mdata_q  <= 16'd0;
      addr_q   <= 42'd0;
    end else begin
      timer_q  <= timer_d;
      base_q   <= base_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      mdata_q  <= mdata_d;
      addr_q   <= addr_d;
    end
  end

  assign rd_valid_o    = valid_q;
  assign rd_mdata_o    = mdata_q;
  assign rd_addr_o     = addr_q;
  assign rd_issued_o   = issued_q;
  assign rd_run_done_o = done_q;

endmodule

// File: doc/rd_req_engine.md
Name: rd_req_engine

Overview:
- Read-request generator feeding the AFU top-level request path (c0Tx header build).
- In control phase: polls the CPU control cache line at ctrl_addr with READ_CTRL_MDATA until the AFU leaves control state.
- In run phase: issues num_cls sequential data-line reads starting at the run read address, tagged READ_RUN_MDATA, honouring a stall input.
- Reports requests-issued count and run-issue completion.

Parameters:
- CTRL_MDATA, 16'h0001, mdata tag for control-word reads
- RUN_MDATA, 16'h0002, mdata tag for run data reads
- POLL_GAP, 64, idle cycles between control response and next poll (>=1)
- CTRL_TIMEOUT, 4096, cycles waiting for a control response before re-issuing

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  1 = do not launch a request this cycle (c0TxAlmFull or FIFO overflow risk)
- afu_state_in  in  3  AFU state: 0 IDLE, 1 CTRL, 2 RUN, 3 DONE, 4 SHUTDOWN_WAIT, 5 SHUTDOWN
- ctrl_addr  in  42  cache-line address of control word
- ctrl_resp_valid  in  1  control-line read response decoded (1-cycle pulse)
- run_rd_addr  in  42  base CL address for run reads (from control response)
- run_num_cls  in  32  number of CLs to read this run
- rd_valid  out  1  request valid (registered)
- rd_mdata  out  16  request mdata
- rd_addr  out  42  request CL address
- rd_issued  out  32  run reads issued since RUN entry
- rd_run_done  out  1  all run reads issued

Behaviour:
- Reset (reset_n=0, async): engine state S_IDLE; rd_valid=0, rd_mdata=0, rd_addr=0, rd_issued=0, rd_run_done=0; all timers 0. Reset asserted mid-run aborts immediately; no request emitted after deassertion until the state machine re-enters via afu_state_in.
- All outputs registered. A launch decided in cycle N appears on rd_valid in cycle N+1 for exactly one cycle.
- Launch rule: a launch occurs in cycle N only if stall=0 in cycle N. Stall never drops a request; the pending request is held and launched in the first stall=0 cycle.
- Engine FSM:
  - S_IDLE: rd_valid=0.
    - afu_state_in==CTRL -> S_CTRL_ISSUE.
    - afu_state_in==RUN -> S_RUN. On entry: latch run_rd_addr into base, run_num_cls into count, clear rd_issued and rd_run_done.
  - S_CTRL_ISSUE: launch one read with addr=ctrl_addr, mdata=CTRL_MDATA when stall=0. Then go to S_CTRL_WAIT and clear the timer.
  - S_CTRL_WAIT:
    - ctrl_resp_valid -> S_CTRL_GAP.
    - Timer reaches CTRL_TIMEOUT-1 -> S_CTRL_ISSUE.
  - S_CTRL_GAP: count POLL_GAP cycles, then -> S_CTRL_ISSUE.
  - S_RUN: each launch uses addr=base+rd_issued (42-bit wrap, modulo 2^42) and mdata=RUN_MDATA; rd_issued increments in the same register update as rd_valid.
    - When rd_issued==count: no further launches, rd_run_done=1 (registered, same cycle the final rd_issued value appears).
    - count==0: rd_run_done=1 one cycle after entry, zero launches.
  - S_RUN_DONE: rd_run_done held at 1; rd_issued frozen.
- Exit rule: from any CTRL-family or RUN state, afu_state_in not equal to the owning phase -> S_IDLE next cycle; pending unlaunched request discarded.
  - A launch already decided in that cycle still appears.
  - rd_issued and rd_run_done retain their values until the next RUN entry.
- Simultaneous events:
  - ctrl_resp_valid in the same cycle as a timeout -> response wins (S_CTRL_GAP).
  - ctrl_resp_valid outside S_CTRL_WAIT is ignored.
  - State change and launch in the same cycle: the launch completes, then the engine goes to S_IDLE.
- Max one request per cycle; back-to-back launches permitted with no bubble when stall=0.
- SHUTDOWN_WAIT, SHUTDOWN, DONE: treated as IDLE (no requests).

Test Plan:
- Reset then afu_state_in=CTRL, ctrl_addr=0x100, stall=0 -> rd_valid pulse 2 cycles after state set, rd_addr=0x100, rd_mdata=0x0001; no further requests until ctrl_resp_valid.
- CTRL, ctrl_resp_valid 10 cycles after the request, POLL_GAP=64 -> next control request exactly 64 cycles plus fixed FSM overhead later (same value every poll); no timeout-triggered reissue.
- CTRL with no response, CTRL_TIMEOUT=16 -> control requests repeat every 16 cycles plus issue overhead.
- RUN, run_rd_addr=0x1000, run_num_cls=8, stall=0 -> 8 consecutive rd_valid pulses, addrs 0x1000..0x1007, mdata=0x0002; rd_issued=8; rd_run_done=1; no ninth request.
- RUN, num_cls=4, stall high on cycles 2-5 after entry -> still exactly 4 requests, sequential addresses, none launched while stall=1.
- Edge cases:
  - RUN with run_rd_addr=2^42-2, num_cls=4 -> addrs wrap to 0, 1.
  - num_cls=0 -> no requests, rd_run_done=1.
  - reset_n pulsed low mid-run -> all outputs 0 immediately, asynchronously.
